// File: rtl/trace_player.sv
// Trace-driven stimulus generator for the vPIFO tree: prefetches trace ROM
// records into a 2-entry FIFO and issues push/pop ops over valid/ready.
module trace_player #(
    parameter int PTW       = 16,
    parameter int MTW       = 16,
    parameter int TREE_NUM  = 4,
    parameter int IDLECYCLE = 1024,
    parameter int ROM_SIZE  = 8,
    parameter int LOOP_W    = 8,
    parameter int CNT_W     = 32,
    localparam int TREE_NUM_BITS   = $clog2(TREE_NUM),
    localparam int IDLECYCLE_BITS  = $clog2(IDLECYCLE),
    localparam int ROM_WIDTH       = $clog2(ROM_SIZE),
    localparam int PD_W            = MTW + PTW,
    localparam int REC_W           = PTW + TREE_NUM_BITS + PD_W,
    localparam int TRACE_DATA_BITS =
        ((IDLECYCLE_BITS > REC_W) ? IDLECYCLE_BITS : REC_W) + 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [LOOP_W-1:0]          i_loop_count,
    output logic                       o_read,
    output logic [ROM_WIDTH-1:0]       o_read_addr,
    input  logic [TRACE_DATA_BITS-1:0] i_trace_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       o_push,
    output logic [PTW-1:0]             o_push_priority,
    output logic [TREE_NUM_BITS-1:0]   o_push_tree_id,
    output logic [PD_W-1:0]            o_push_data,
    output logic                       o_pop,
    output logic [TREE_NUM_BITS-1:0]   o_pop_tree_id,
    output logic                       o_busy,
    output logic                       o_finish,
    output logic [CNT_W-1:0]           o_push_cnt,
    output logic [CNT_W-1:0]           o_pop_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam int TR_LO = PD_W;
    localparam int PR_LO = PD_W + TREE_NUM_BITS;
    localparam int TY_LO = TRACE_DATA_BITS - 2;

    state_e                     state_q;
    logic [LOOP_W-1:0]          loops_q;
    logic [ROM_WIDTH-1:0]       addr_q;
    logic                       inflight_q;
    logic                       stop_q;
    logic                       addr_done_q;
    logic [TRACE_DATA_BITS-1:0] mem_q [2];
    logic                       wp_q;
    logic                       rp_q;
    logic [1:0]                 occ_q;
    logic [1:0]                 occ_d;
    logic [IDLECYCLE_BITS-1:0]  idle_q;
    logic                       finish_q;
    logic [CNT_W-1:0]           push_cnt_q;
    logic [CNT_W-1:0]           pop_cnt_q;

    logic [TRACE_DATA_BITS-1:0] head;
    logic [1:0]                 htype;
    logic                       run;
    logic                       head_ok;
    logic                       is_op;
    logic                       fire;
    logic                       consume;
    logic                       end_head;
    logic                       capture;
    logic                       is_end;
    logic                       wr;
    logic                       rd;
    logic [2:0]                 fill;

    always_comb begin
        head     = mem_q[rp_q];
        htype    = head[TY_LO +: 2];
        run      = (state_q == S_RUN);
        head_ok  = run && (occ_q != 2'd0) && (idle_q == '0);
        is_op    = head_ok && (htype != T_IDLE);
        fire     = is_op && i_ready;
        consume  = fire || (head_ok && (htype == T_IDLE));
        // END reaches the head once the FIFO drains behind a stop condition
        end_head = run && (occ_q == 2'd0) && (idle_q == '0) &&
                   (stop_q || (addr_done_q && !inflight_q));
        capture  = run && inflight_q && !stop_q;
        is_end   = capture && (i_trace_data[TY_LO +: 2] == T_IDLE) &&
                   (&i_trace_data[IDLECYCLE_BITS-1:0]);
        wr       = capture && !is_end;
        fill     = 3'(occ_q) + 3'(inflight_q) - 3'(consume);
        rd       = run && !stop_q && !addr_done_q && (fill < 3'd2);
        occ_d    = occ_q + {1'b0, wr} - {1'b0, consume};
    end

    always_comb begin
        o_read          = rd;
        o_read_addr     = addr_q;
        o_valid         = is_op;
        o_push          = is_op && htype[0];
        o_pop           = is_op && htype[1];
        o_push_priority = o_push ? head[PR_LO +: PTW] : '1;
        o_push_tree_id  = o_push ? head[TR_LO +: TREE_NUM_BITS] : '0;
        o_push_data     = o_push ? head[PD_W-1:0] : '1;
        o_pop_tree_id   = o_pop ? head[TR_LO +: TREE_NUM_BITS] : '0;
        o_busy          = (state_q != S_IDLE);
        o_finish        = finish_q;
        o_push_cnt      = push_cnt_q;
        o_pop_cnt       = pop_cnt_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            loops_q     <= '0;
            addr_q      <= '0;
            inflight_q  <= 1'b0;
            stop_q      <= 1'b0;
            addr_done_q <= 1'b0;
            wp_q        <= 1'b0;
            rp_q        <= 1'b0;
            occ_q       <= 2'd0;
            idle_q      <= '0;
            finish_q    <= 1'b0;
            push_cnt_q  <= '0;
            pop_cnt_q   <= '0;
        end else begin
            finish_q   <= 1'b0;
            inflight_q <= rd;
            unique case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_q     <= S_RUN;
                        loops_q     <= i_loop_count;
                        addr_q      <= '0;
                        stop_q      <= 1'b0;
                        addr_done_q <= 1'b0;
                        wp_q        <= 1'b0;
                        rp_q        <= 1'b0;
                        occ_q       <= 2'd0;
                        idle_q      <= '0;
                        push_cnt_q  <= '0;
                        pop_cnt_q   <= '0;
                    end
                end
                S_RUN: begin
                    if (rd) begin
                        addr_q <= addr_q + 1'b1;
                        if (addr_q == ROM_WIDTH'(ROM_SIZE - 1))
                            addr_done_q <= 1'b1;
                    end
                    if (wr) begin
                        mem_q[wp_q] <= i_trace_data;
                        wp_q        <= ~wp_q;
                    end
                    if (is_end)
                        stop_q <= 1'b1;
                    if (consume)
                        rp_q <= ~rp_q;
                    occ_q <= occ_d;
                    if (consume && (htype == T_IDLE))
                        idle_q <= head[IDLECYCLE_BITS-1:0];
                    else if (idle_q != '0)
                        idle_q <= idle_q - 1'b1;
                    if (fire && htype[0] && !(&push_cnt_q))
                        push_cnt_q <= push_cnt_q + 1'b1;
                    if (fire && htype[1] && !(&pop_cnt_q))
                        pop_cnt_q <= pop_cnt_q + 1'b1;
                    if (end_head) begin
                        if (loops_q != '0) begin
                            loops_q     <= loops_q - 1'b1;
                            addr_q      <= '0;
                            stop_q      <= 1'b0;
                            addr_done_q <= 1'b0;
                        end else begin
                            state_q  <= S_DRAIN;
                            finish_q <= 1'b1;
                        end
                    end
                end
                S_DRAIN: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
